mont_mul_serial: RTL

- Parametrised bit-serial radix-2 Montgomery multiplier: result = A·B·2^(−WIDTH) mod P.
- Carry-save accumulator with one multiplier bit per cycle, then one carry-propagate resolve cycle, then an optional conditional final subtraction.
- Successor to the fixed 256-bit Montgomery datapath. Adds a width parameter, a start/busy/done handshake with latched operands, deterministic latency and a fully reduced output.
- Sits under the field-arithmetic layer of the ECC point unit, driven by the point-op sequencer.

---
 rtl/mont_mul_serial.sv | 98 +++++++++
 1 files changed

// File: rtl/mont_mul_serial.sv
// mont_mul_serial: bit-serial radix-2 Montgomery multiplier, result = a*b*2^-WIDTH mod p
//   clk, rst_n     : rising-edge clock, asynchronous active-low reset
//   start          : request, sampled only while idle (not busy)
//   a, b, p        : multiplicand (scanned LSB first), multiplier, odd modulus; latched on accept
//   busy           : operation in flight; drops on the edge that raises done
//   done           : one-cycle pulse, result valid from this cycle
//   result         : Montgomery product, held until the next done
module mont_mul_serial #(
    parameter int WIDTH     = 256,
    parameter bit FINAL_SUB = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] p,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    localparam int AW = WIDTH + 2;
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, ITER, RESOLVE, SUB} state_t;
    state_t           state;
    logic [WIDTH-1:0] a_r, b_r, p_r;
    logic [AW-1:0]    s, c;
    logic [WIDTH:0]   r;
    logic [CW-1:0]    cnt;
    logic [AW:0]      x, sum1, car1, qp;
    logic             q;
    logic [AW-1:0]    rsum;
    logic [WIDTH+1:0] diff;
    // Two 3:2 compressor layers: (s, c, a_i*b) then (+ q*p). q is the LSB of the
    // first layer's sum word, since its carry word is always even. The sum word of
    // the second layer is even (p odd) and its carry word is a left-shifted majority,
    // so halving drops the shift on the carry and bit 0 of the sum.
    always_comb begin
        x    = a_r[cnt] ? (AW+1)'(b_r) : '0;
        sum1 = {1'b0, s} ^ {1'b0, c} ^ x;
        car1 = (({1'b0, s} & {1'b0, c}) | ({1'b0, s} & x) | ({1'b0, c} & x)) << 1;
        q    = sum1[0];
        qp   = q ? (AW+1)'(p_r) : '0;
        rsum = s + c;
        diff = {1'b0, r} - {2'b0, p_r};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            a_r    <= '0;
            b_r    <= '0;
            p_r    <= '0;
            s      <= '0;
            c      <= '0;
            r      <= '0;
            cnt    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    a_r   <= a;
                    b_r   <= b;
                    p_r   <= p;
                    s     <= '0;
                    c     <= '0;
                    cnt   <= '0;
                    busy  <= 1'b1;
                    state <= ITER;
                end
                ITER: begin
                    s     <= AW'((sum1 ^ car1 ^ qp) >> 1);
                    c     <= AW'((sum1 & car1) | (sum1 & qp) | (car1 & qp));
                    cnt   <= cnt + 1'b1;
                    state <= (cnt == CW'(WIDTH - 1)) ? RESOLVE : ITER;
                end
                RESOLVE: if (FINAL_SUB) begin
                    r     <= rsum[WIDTH:0];
                    state <= SUB;
                end else begin
                    result <= rsum[WIDTH-1:0];
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                SUB: begin
                    // borrow of r - p selects r itself when r < p
                    result <= diff[WIDTH+1] ? r[WIDTH-1:0] : diff[WIDTH-1:0];
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule
